// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32->32 multiplier cell among NUM_REQ requesters.
// Optional perf counters (perf_clr, perf_busy_cycles, perf_stall_cycles) under MUL_SHARE_PERF_EN.

module mul_share_rsp_slot (
   input  logic        clk,
   input  logic        reset,
   input  logic        accept,
   input  logic        capture,
   input  logic [31:0] cell_result,
   input  logic        rsp_ready,
   output logic        pend,
   output logic        rsp_valid,
   output logic [31:0] rsp_result
);
   logic pop_q;

   // pend drops one edge after the pop, so a requester re-arms no earlier than the cycle after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         pop_q      <= 1'b0;
      end else begin
         pop_q <= rsp_valid && rsp_ready;
         if (accept)     pend <= 1'b1;
         else if (pop_q) pend <= 1'b0;
         if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= cell_result;
         end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
      end
   end
endmodule

module mul_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 1,
   parameter int IDX_W       = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0][31:0] req_src1,
   input  logic [NUM_REQ-1:0][31:0] req_src2,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [NUM_REQ-1:0][31:0] rsp_result,
   output logic [31:0]              cell_src1,
   output logic [31:0]              cell_src2,
   input  logic [31:0]              cell_result,
   output logic                     busy
`ifdef MUL_SHARE_PERF_EN
   ,
   input  logic                     perf_clr,
   output logic [31:0]              perf_busy_cycles,
   output logic [31:0]              perf_stall_cycles
`endif
);
   logic [IDX_W-1:0]                  ptr;
   logic [IDX_W-1:0]                  grant_idx;
   logic [IDX_W:0]                    cand;
   logic                              grant_vld;
   logic [NUM_REQ-1:0]                pend;
   logic [NUM_REQ-1:0]                eligible;
   logic [NUM_REQ-1:0]                grant;
   logic [NUM_REQ-1:0]                capture;
   logic [MUL_LATENCY:0]              vld_pipe;
   logic [MUL_LATENCY:0][IDX_W-1:0]   idx_pipe;
   logic [MUL_LATENCY-1:0]            vld_q;
   logic [MUL_LATENCY-1:0][IDX_W-1:0] idx_q;

   assign eligible = req_valid & ~pend & {NUM_REQ{~reset}};

   // First eligible index at or after ptr, wrapping at NUM_REQ (not necessarily a power of two).
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   assign req_ready = grant;
   assign cell_src1 = grant_vld ? req_src1[grant_idx] : '0;
   assign cell_src2 = grant_vld ? req_src2[grant_idx] : '0;
   assign busy      = |pend;

   always_ff @(posedge clk) begin
      if (reset)          ptr <= '0;
      else if (grant_vld) ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
   end

   // Tag pipe tracks the cell's register stages; stage 0 is the live grant.
   assign vld_pipe = {vld_q, grant_vld};
   assign idx_pipe = {idx_q, grant_idx};

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_pipe[MUL_LATENCY-1:0];
         idx_q <= idx_pipe[MUL_LATENCY-1:0];
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign capture[gi] = vld_pipe[MUL_LATENCY] && (idx_pipe[MUL_LATENCY] == IDX_W'(gi));
      mul_share_rsp_slot u_slot (
         .clk         (clk),
         .reset       (reset),
         .accept      (grant[gi]),
         .capture     (capture[gi]),
         .cell_result (cell_result),
         .rsp_ready   (rsp_ready[gi]),
         .pend        (pend[gi]),
         .rsp_valid   (rsp_valid[gi]),
         .rsp_result  (rsp_result[gi])
      );
   end

`ifdef MUL_SHARE_PERF_EN
   logic stall;
   assign stall = |(eligible & ~grant);

   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if ((|vld_q) && (perf_busy_cycles != '1))  perf_busy_cycles  <= perf_busy_cycles + 32'd1;
         if (stall && (perf_stall_cycles != '1))    perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a registered low-word multiplier cell model.
module tb_mul_share_arbiter;
   localparam int N  = 4;
   localparam int ML = 1;
   localparam int IW = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [N-1:0]       req_valid = '0, rsp_ready = '0;
   logic [N-1:0]       req_ready, rsp_valid;
   logic [N-1:0][31:0] req_src1 = '0, req_src2 = '0;
   logic [N-1:0][31:0] rsp_result;
   logic [31:0]        cell_src1, cell_src2, cell_result;
   logic               busy;
   logic [ML-1:0][31:0] cell_pipe;
`ifdef MUL_SHARE_PERF_EN
   logic               perf_clr = 1'b0;
   logic [31:0]        perf_busy_cycles, perf_stall_cycles;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Multiplier cell: product registered through ML stages.
   always @(posedge clk) begin
      cell_pipe[0] <= cell_src1 * cell_src2;
      for (int s = 1; s < ML; s++) cell_pipe[s] <= cell_pipe[s-1];
   end
   assign cell_result = cell_pipe[ML-1];

   mul_share_arbiter #(.NUM_REQ(N), .MUL_LATENCY(ML), .IDX_W(IW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .cell_src1   (cell_src1),
      .cell_src2   (cell_src2),
      .cell_result (cell_result),
      .busy        (busy)
`ifdef MUL_SHARE_PERF_EN
      ,
      .perf_clr          (perf_clr),
      .perf_busy_cycles  (perf_busy_cycles),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1;
      req_src1[0] = 32'hDEAD_BEEF;
      req_src2[0] = 32'h0000_0005;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
      checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
      checks++; if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0) begin errors++; $display("FAIL reset_cell_src: got %h/%h want 0/0", cell_src1, cell_src2); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      req_src1[1] = 32'h0001_2345;
      req_src2[1] = 32'h0000_0100;
      rsp_ready = '0;
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", req_ready); end
      checks++; if (cell_src1 !== 32'h0001_2345) begin errors++; $display("FAIL single_cell_src1: got %h want 00012345", cell_src1); end
      checks++; if (cell_src2 !== 32'h0000_0100) begin errors++; $display("FAIL single_cell_src2: got %h want 00000100", cell_src2); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_valid: got %b want 0000", rsp_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      checks++; if (cell_src1 !== 32'h0) begin errors++; $display("FAIL single_idle_cell: got %h want 0", cell_src1); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
      checks++; if (rsp_result[1] !== 32'h0123_4500) begin errors++; $display("FAIL single_result: got %h want 01234500", rsp_result[1]); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_result[1] !== 32'h0123_4500) begin errors++; $display("FAIL single_hold: got %b/%h want 0010/01234500", rsp_valid, rsp_result[1]); end
      rsp_ready = 4'b0010;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_pop: got %b want 0000", rsp_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_pop: got %b want 1", busy); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b want 0", busy); end
      rsp_ready = '0;
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_g;
      for (int i = 0; i < N; i++) begin
         req_src1[i] = 32'(i + 2);
         req_src2[i] = 32'd3;
      end
      rsp_ready = '1;
      req_valid = '1;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_g = 4'b0001 << (c % 4);
         checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL contention_grant c%0d: got %b want %b", c, req_ready, exp_g); end
         checks++; if (cell_src1 !== 32'(c % 4 + 2)) begin errors++; $display("FAIL contention_cell c%0d: got %h want %h", c, cell_src1, 32'(c % 4 + 2)); end
         if (c == 2) begin
            checks++; if (rsp_valid !== 4'b0001 || rsp_result[0] !== 32'd6) begin errors++; $display("FAIL contention_rsp0: got %b/%h want 0001/6", rsp_valid, rsp_result[0]); end
         end
         if (c == 3) begin
            checks++; if (rsp_valid !== 4'b0010 || rsp_result[1] !== 32'd9) begin errors++; $display("FAIL contention_rsp1: got %b/%h want 0010/9", rsp_valid, rsp_result[1]); end
         end
         @(negedge clk);
      end
`ifdef MUL_SHARE_PERF_EN
      #1;
      checks++; if (perf_stall_cycles !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cycles); end
      checks++; if (perf_busy_cycles !== 32'd7) begin errors++; $display("FAIL perf_busy: got %0d want 7", perf_busy_cycles); end
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
      #1;
      checks++; if (perf_stall_cycles !== 32'd0 || perf_busy_cycles !== 32'd0) begin errors++; $display("FAIL perf_clr: got %0d/%0d want 0/0", perf_stall_cycles, perf_busy_cycles); end
`endif
      req_valid = '0;
      repeat (6) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL contention_drain: got busy %b valid %b want 0/0000", busy, rsp_valid); end
      rsp_ready = '0;
   endtask

   task automatic test_wrap();
      int unsigned wi [3];
      logic [31:0] wa [3];
      logic [31:0] wb [3];
      logic [31:0] we [3];
      wi = '{3, 0, 2};
      wa = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFE};
      wb = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0003};
      we = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFA};
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         req_src1[wi[t]] = wa[t];
         req_src2[wi[t]] = wb[t];
         req_valid = '0;
         req_valid[wi[t]] = 1'b1;
         #1;
         checks++; if (req_ready[wi[t]] !== 1'b1) begin errors++; $display("FAIL wrap_grant t%0d: got %b want bit %0d", t, req_ready, wi[t]); end
         @(negedge clk);
         req_valid = '0;
         @(negedge clk); #1;
         checks++; if (rsp_valid[wi[t]] !== 1'b1 || rsp_result[wi[t]] !== we[t]) begin errors++; $display("FAIL wrap_result t%0d: got %b/%h want 1/%h", t, rsp_valid[wi[t]], rsp_result[wi[t]], we[t]); end
         rsp_ready = '1;
         @(negedge clk);
         rsp_ready = '0;
      end
   endtask

   task automatic test_backpressure();
      int grants;
      for (int i = 0; i < N; i++) begin
         req_src1[i] = 32'(i + 1);
         req_src2[i] = 32'd7;
      end
      req_src1[2] = 32'h0000_1234;
      req_src2[2] = 32'h0000_0010;
      rsp_ready = 4'b1011;
      req_valid = 4'b0100;
      do_reset();
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant: got %b want 0100", req_ready); end
      @(negedge clk);
      req_valid = '1;
      @(negedge clk);
      grants = 0;
      for (int c = 2; c < 12; c++) begin
         #1;
         checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_blocked c%0d: got %b want 0", c, req_ready[2]); end
         checks++; if (rsp_valid[2] !== 1'b1 || rsp_result[2] !== 32'h0001_2340) begin errors++; $display("FAIL bp_hold c%0d: got %b/%h want 1/00012340", c, rsp_valid[2], rsp_result[2]); end
         if (req_ready != '0) grants++;
         @(negedge clk);
      end
      checks++; if (grants !== 8) begin errors++; $display("FAIL bp_others_grants: got %0d want 8", grants); end
      req_valid = 4'b0100;
      rsp_ready = '1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_pop_cycle: got %b want 0000", req_ready); end
      @(negedge clk); #1;
      checks++; if (rsp_valid[2] !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_after_pop: got %b/%b want 0/0000", rsp_valid[2], req_ready); end
      @(negedge clk); #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_regrant: got %b want 0100", req_ready); end
      req_valid = '0;
      repeat (6) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", busy); end
      rsp_ready = '0;
   endtask

   task automatic test_reset_midflight();
      req_src1[1] = 32'd7;
      req_src2[1] = 32'd9;
      req_src1[0] = 32'h0000_00AB;
      rsp_ready = '0;
      req_valid = '0;
      do_reset();
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b want 0010", req_ready); end
      @(negedge clk);
      req_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_quiet c%0d: got %b/%b want 0000/0", c, rsp_valid, busy); end
         @(negedge clk);
      end
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
      checks++; if (cell_src1 !== 32'h0000_00AB) begin errors++; $display("FAIL mid_cell_src1: got %h want 000000AB", cell_src1); end
      @(negedge clk);
      req_valid = '0;
      rsp_ready = '1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_backpressure();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
